// File: rtl/reg32_req_sequencer.sv
// Access sequencer in front of a 16x32 register file.
// Buffers bus writes in a small FIFO and drains them one per cycle. Reads are
// served one at a time and stall while any buffered or same-cycle write
// targets the same index.
// Ports:
//   clk, reset                          clock, async active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data   write request channel
//   rd_valid/rd_ready/rd_addr           read request channel
//   rsp_valid/rsp_ready/rsp_data        read response channel
//   rf_hold                             register file port busy, issue nothing
//   write_en/write_line/wr_rf_data      register file write strobe (registered)
//   read_en/read_line/rf_rdata          register file read strobe (registered) and data
//   fifo_level                          number of buffered writes
module reg32_req_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  input  logic                        rf_hold,
  output logic                        write_en,
  output logic [ADDR_W-1:0]           write_line,
  output logic [DATA_W-1:0]           wr_rf_data,
  output logic                        read_en,
  output logic [ADDR_W-1:0]           read_line,
  input  logic [DATA_W-1:0]           rf_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RSP   = 2'd2
  } state_e;

  logic [ADDR_W-1:0]     addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]     data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  fifo_empty, fifo_full, push, pop, hazard;
  logic [ADDR_W-1:0]     pop_addr;
  logic [DATA_W-1:0]     pop_data;

  logic                  write_en_q;
  logic [ADDR_W-1:0]     write_line_q;
  logic [DATA_W-1:0]     wr_rf_data_q;
  logic                  read_en_q;
  logic [ADDR_W-1:0]     read_line_q;
  logic [DATA_W-1:0]     rsp_data_q;
  state_e                state_q, state_d;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign wr_ready   = !fifo_full;
  assign push       = wr_valid && wr_ready;
  // An empty FIFO lets the incoming write pass straight through so it
  // reaches the register file in the very next cycle.
  assign pop        = !rf_hold && (!fifo_empty || push);
  assign pop_addr   = fifo_empty ? wr_addr : addr_mem[rd_ptr_q];
  assign pop_data   = fifo_empty ? wr_data : data_mem[rd_ptr_q];

  // Entry occupancy and level; a bypassed write sets and clears the same slot.
  always_comb begin
    vld_d = vld_q;
    if (push) vld_d[wr_ptr_q] = 1'b1;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  // Read hazard: any buffered write or same-cycle push to the read index.
  always_comb begin
    hazard = push && (wr_addr == rd_addr);
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_q[PTR_W'(i)] && (addr_mem[PTR_W'(i)] == rd_addr)) hazard = 1'b1;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      vld_q   <= vld_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= wr_addr;
      data_mem[wr_ptr_q] <= wr_data;
    end
  end

  // Register file write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_en_q   <= 1'b0;
      write_line_q <= '0;
      wr_rf_data_q <= '0;
    end else begin
      write_en_q <= pop;
      if (pop) begin
        write_line_q <= pop_addr;
        wr_rf_data_q <= pop_data;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Read FSM next state; ISSUE only advances once the strobe actually went out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rd_valid && rd_ready) state_d = S_ISSUE;
      S_ISSUE: if (read_en_q)            state_d = S_RSP;
      S_RSP:   if (rsp_ready)            state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // Read FSM handshake outputs.
  always_comb begin
    rd_ready  = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:  rd_ready  = rd_valid && !rf_hold && !hazard;
      S_RSP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Read strobe, latched index and captured response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_en_q   <= 1'b0;
      read_line_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      read_en_q <= (state_d == S_ISSUE) && !rf_hold;
      if ((state_q == S_IDLE) && rd_valid && rd_ready) read_line_q <= rd_addr;
      if ((state_q == S_ISSUE) && read_en_q)           rsp_data_q  <= rf_rdata;
    end
  end

  assign write_en   = write_en_q;
  assign write_line = write_line_q;
  assign wr_rf_data = wr_rf_data_q;
  assign read_en    = read_en_q;
  assign read_line  = read_line_q;
  assign rsp_data   = rsp_data_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_reg32_req_sequencer.sv
// Bench for reg32_req_sequencer with a simple 16x32 register file behind it.
`timescale 1ns/1ps
module tb_reg32_req_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, write_line, read_line;
  logic [DW-1:0] wr_data, rsp_data, wr_rf_data, rf_rdata;
  logic          rsp_valid, rsp_ready, rf_hold, write_en, read_en;
  logic [2:0]    fifo_level;
  logic [DW-1:0] rf_mem [16] = '{default: '0};

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  reg32_req_sequencer dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rf_hold(rf_hold),
    .write_en(write_en), .write_line(write_line), .wr_rf_data(wr_rf_data),
    .read_en(read_en), .read_line(read_line), .rf_rdata(rf_rdata),
    .fifo_level(fifo_level)
  );

  // Register file: synchronous write, combinational read.
  always @(posedge clk) if (write_en) rf_mem[write_line] <= wr_rf_data;
  assign rf_rdata = rf_mem[read_line];

  task automatic drive_idle();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0;
    rsp_ready = 1'b1; rf_hold = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL por_wr_ready got %b exp 1", wr_ready); end
    tests_run++; if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL por_level got %0d exp 0", fifo_level); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL por_rsp_valid got %b exp 0", rsp_valid); end
    // Read to 0 parked in RSP, then three writes stuck behind rf_hold.
    @(negedge clk); rd_valid = 1'b1; rd_addr = 4'd0; rsp_ready = 1'b0; #1;
    tests_run++; if (rd_ready !== 1'b1) begin tests_failed++; $display("FAIL t1_rd_ready got %b exp 1", rd_ready); end
    @(negedge clk); rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rf_hold = 1'b1; wr_valid = 1'b1; wr_addr = AW'(i + 1); wr_data = $urandom;
    end
    @(negedge clk); wr_valid = 1'b0; #1;
    tests_run++; if (fifo_level !== 3'd3) begin tests_failed++; $display("FAIL t1_level_pre got %0d exp 3", fifo_level); end
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL t1_rsp_pre got %b exp 1", rsp_valid); end
    reset = 1'b1; #1;
    tests_run++; if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL t1_level got %0d exp 0", fifo_level); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL t1_rsp_valid got %b exp 0", rsp_valid); end
    tests_run++; if (write_en !== 1'b0) begin tests_failed++; $display("FAIL t1_write_en got %b exp 0", write_en); end
    tests_run++; if (read_en !== 1'b0) begin tests_failed++; $display("FAIL t1_read_en got %b exp 0", read_en); end
    tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL t1_wr_ready got %b exp 1", wr_ready); end
    @(negedge clk); reset = 1'b0; drive_idle();
    @(negedge clk); #1;
    tests_run++; if (write_en !== 1'b0 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL t1_dropped got we=%b rv=%b exp 0 0", write_en, rsp_valid); end
  endtask

  task automatic test_write_read();
    @(negedge clk); wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF; #1;
    tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL t2_wr_ready got %b exp 1", wr_ready); end
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd3; #1;
    tests_run++; if (write_en !== 1'b1 || write_line !== 4'd3 || wr_rf_data !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL t2_write got en=%b line=%0d data=%h exp 1 3 deadbeef", write_en, write_line, wr_rf_data); end
    tests_run++; if (rd_ready !== 1'b1) begin tests_failed++; $display("FAIL t2_rd_ready got %b exp 1", rd_ready); end
    @(negedge clk); rd_valid = 1'b0; #1;
    tests_run++; if (read_en !== 1'b1 || read_line !== 4'd3 || rsp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL t2_issue got en=%b line=%0d rv=%b exp 1 3 0", read_en, read_line, rsp_valid); end
    @(negedge clk); #1;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL t2_rsp got rv=%b data=%h exp 1 deadbeef", rsp_valid, rsp_data); end
    @(negedge clk); #1;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL t2_rsp_done got %b exp 0", rsp_valid); end
  endtask

  task automatic test_full();
    logic [DW-1:0] d [5];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); rf_hold = 1'b1; wr_valid = 1'b1; wr_addr = AW'(8 + i); d[i] = $urandom; wr_data = d[i]; #1;
      tests_run++; if (wr_ready !== (i < 4)) begin tests_failed++; $display("FAIL t3_wr_ready_%0d got %b exp %b", i, wr_ready, (i < 4)); end
    end
    @(negedge clk); wr_valid = 1'b0; #1;
    tests_run++; if (fifo_level !== 3'd4 || wr_ready !== 1'b0) begin
      tests_failed++; $display("FAIL t3_full got level=%0d rdy=%b exp 4 0", fifo_level, wr_ready); end
    tests_run++; if (write_en !== 1'b0) begin tests_failed++; $display("FAIL t3_hold_we got %b exp 0", write_en); end
    @(negedge clk); rf_hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      tests_run++; if (write_en !== 1'b1 || write_line !== AW'(8 + k) || wr_rf_data !== d[k]) begin
        tests_failed++; $display("FAIL t3_drain_%0d got en=%b line=%0d data=%h exp 1 %0d %h", k, write_en, write_line, wr_rf_data, 8 + k, d[k]); end
    end
    @(negedge clk); #1;
    tests_run++; if (write_en !== 1'b0 || fifo_level !== 3'd0) begin
      tests_failed++; $display("FAIL t3_empty got en=%b level=%0d exp 0 0", write_en, fifo_level); end
  endtask

  task automatic test_hazard();
    @(negedge clk); rf_hold = 1'b1; wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 32'h1234;
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd5; #1;
    tests_run++; if (rd_ready !== 1'b0) begin tests_failed++; $display("FAIL t4_hold_rd5 got %b exp 0", rd_ready); end
    rd_addr = 4'd6; #1;
    tests_run++; if (rd_ready !== 1'b0) begin tests_failed++; $display("FAIL t4_hold_rd6 got %b exp 0", rd_ready); end
    @(negedge clk); rf_hold = 1'b0; rd_addr = 4'd5; #1;
    tests_run++; if (rd_ready !== 1'b0) begin tests_failed++; $display("FAIL t4_hazard_rd5 got %b exp 0", rd_ready); end
    rd_addr = 4'd6; #1;
    tests_run++; if (rd_ready !== 1'b1) begin tests_failed++; $display("FAIL t4_rd6_accept got %b exp 1", rd_ready); end
    @(negedge clk); rd_valid = 1'b0;
    @(negedge clk); #1;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      tests_failed++; $display("FAIL t4_rsp6 got rv=%b data=%h exp 1 0", rsp_valid, rsp_data); end
    @(negedge clk); rd_valid = 1'b1; rd_addr = 4'd5; #1;
    tests_run++; if (rd_ready !== 1'b1) begin tests_failed++; $display("FAIL t4_rd5_accept got %b exp 1", rd_ready); end
    @(negedge clk); rd_valid = 1'b0;
    @(negedge clk); #1;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234) begin
      tests_failed++; $display("FAIL t4_rsp5 got rv=%b data=%h exp 1 00001234", rsp_valid, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk); rd_valid = 1'b1; rd_addr = 4'd3; rsp_ready = 1'b0; #1;
    tests_run++; if (rd_ready !== 1'b1) begin tests_failed++; $display("FAIL t5_accept got %b exp 1", rd_ready); end
    @(negedge clk); rd_addr = 4'd0; #1;
    tests_run++; if (rd_ready !== 1'b0) begin tests_failed++; $display("FAIL t5_issue_rdy got %b exp 0", rd_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rd_ready !== 1'b0) begin
        tests_failed++; $display("FAIL t5_stall_%0d got rv=%b data=%h rdy=%b exp 1 deadbeef 0", i, rsp_valid, rsp_data, rd_ready); end
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL t5_release got %b exp 1", rsp_valid); end
    @(negedge clk); #1;
    tests_run++; if (rsp_valid !== 1'b0 || rd_ready !== 1'b1) begin
      tests_failed++; $display("FAIL t5_idle got rv=%b rdy=%b exp 0 1", rsp_valid, rd_ready); end
    @(negedge clk); rd_valid = 1'b0;
    @(negedge clk); #1;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      tests_failed++; $display("FAIL t5_rsp0 got rv=%b data=%h exp 1 0", rsp_valid, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_regs [16];
    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];
    logic [DW-1:0] rd_exp [$];
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          prev_hold;
    int            init_idx;
    prev_hold = 1'b0;
    init_idx  = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      if (init_idx < 16) begin
        drive_idle(); wr_valid = 1'b1; wr_addr = AW'(init_idx); wr_data = $urandom;
      end else if (cyc < 650) begin
        wr_valid  = ($urandom_range(0, 1) == 1);
        wr_addr   = AW'($urandom_range(0, 7));
        wr_data   = $urandom;
        rd_valid  = ($urandom_range(0, 1) == 1);
        rd_addr   = AW'($urandom_range(0, 7));
        rsp_ready = ($urandom_range(0, 3) != 0);
        rf_hold   = ($urandom_range(0, 4) == 0);
      end else begin
        drive_idle();
      end
      #1;
      if (prev_hold) begin
        tests_run++; if (write_en !== 1'b0 || read_en !== 1'b0) begin
          tests_failed++; $display("FAIL t6_hold cyc=%0d got we=%b re=%b exp 0 0", cyc, write_en, read_en); end
      end
      if (write_en === 1'b1) begin
        tests_run++;
        if (q_addr.size() == 0) begin
          tests_failed++; $display("FAIL t6_extra_write cyc=%0d got line=%0d exp none", cyc, write_line);
        end else begin
          ea = q_addr.pop_front(); ed = q_data.pop_front();
          if (write_line !== ea || wr_rf_data !== ed) begin
            tests_failed++; $display("FAIL t6_write cyc=%0d got %0d/%h exp %0d/%h", cyc, write_line, wr_rf_data, ea, ed); end
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        tests_run++;
        if (rd_exp.size() == 0) begin
          tests_failed++; $display("FAIL t6_extra_rsp cyc=%0d got %h exp none", cyc, rsp_data);
        end else begin
          ed = rd_exp.pop_front();
          if (rsp_data !== ed) begin tests_failed++; $display("FAIL t6_rsp cyc=%0d got %h exp %h", cyc, rsp_data, ed); end
        end
      end
      if (wr_valid && wr_ready === 1'b1) begin
        q_addr.push_back(wr_addr); q_data.push_back(wr_data);
        exp_regs[wr_addr] = wr_data;
        if (init_idx < 16) init_idx++;
      end
      // The write wins a same-cycle conflict, so reads see the newest value.
      if (rd_valid && rd_ready === 1'b1) rd_exp.push_back(exp_regs[rd_addr]);
      prev_hold = rf_hold;
    end
    tests_run++; if (q_addr.size() != 0) begin tests_failed++; $display("FAIL t6_lost_writes got %0d pending exp 0", q_addr.size()); end
    tests_run++; if (rd_exp.size() != 0) begin tests_failed++; $display("FAIL t6_lost_reads got %0d pending exp 0", rd_exp.size()); end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_full();
    test_hazard();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
